// File: rtl/uart_echo_pkg.sv
// Shared types and character constants for the UART echo controller.
// Holds the FSM state encoding and the lower-to-upper case helper.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    PUSH,
    PUSH_LF
  } state_t;

  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] CASE_OFFSET   = 8'h20;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z)) ? (b - CASE_OFFSET) : b;
  endfunction

endpackage

// File: rtl/uart_echo_ctrl.sv
// Echoes bytes from a UART RX FIFO into a TX FIFO, expanding CR into CR LF.
// Optional build macro UART_ECHO_UPCASE_EN folds lower-case letters to upper case.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   echo_en,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_fifo_empty,
  input  logic                   tx_fifo_full,
  output logic                   rx_fifo_pop,
  output logic [7:0]             tx_byte,
  output logic                   transmit,
  output logic [COUNT_WIDTH-1:0] echo_count,
  output logic                   active
);

  state_t     state;
  logic [7:0] data_q;
  logic [7:0] stored_byte;

`ifdef UART_ECHO_UPCASE_EN
  assign stored_byte = to_upper(rx_byte);
`else
  assign stored_byte = rx_byte;
`endif

  // NOTE: transmit is decoded from state and tx_fifo_full in the same cycle so the
  // push lands the moment the TX FIFO frees up; rst masks it so a reset discards the byte.
  assign transmit = !rst && ((state == PUSH) || (state == PUSH_LF)) && !tx_fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_q      <= 8'h00;
      echo_count  <= '0;
      rx_fifo_pop <= 1'b0;
      tx_byte     <= 8'h00;
      active      <= 1'b0;
    end else begin
      rx_fifo_pop <= 1'b0;
      if (transmit) echo_count <= echo_count + COUNT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (echo_en && !rx_fifo_empty) begin
            state       <= POP;
            rx_fifo_pop <= 1'b1;
            active      <= 1'b1;
          end
        end
        POP: state <= CAPTURE;
        CAPTURE: begin
          data_q  <= stored_byte;
          tx_byte <= stored_byte;
          state   <= PUSH;
        end
        PUSH: begin
          if (!tx_fifo_full) begin
            if (data_q == CHAR_CR) begin
              state   <= PUSH_LF;
              tx_byte <= CHAR_LF;
            end else begin
              state   <= IDLE;
              tx_byte <= 8'h00;
              active  <= 1'b0;
            end
          end
        end
        PUSH_LF: begin
          if (!tx_fifo_full) begin
            state   <= IDLE;
            tx_byte <= 8'h00;
            active  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          tx_byte <= 8'h00;
          active  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: a small RX FIFO model feeds the DUT and a
// negedge monitor compares every TX push against a queue of hand-computed bytes.
module tb_uart_echo_ctrl;

  localparam int CW = 4;

`ifdef UART_ECHO_UPCASE_EN
  localparam logic [7:0] EXP_LOWER_A = 8'h41;
  localparam logic [7:0] EXP_LOWER_Z = 8'h5A;
`else
  localparam logic [7:0] EXP_LOWER_A = 8'h61;
  localparam logic [7:0] EXP_LOWER_Z = 8'h7A;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          echo_en = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_fifo_empty;
  logic          tx_fifo_full = 1'b0;
  logic          rx_fifo_pop;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic [CW-1:0] echo_count;
  logic          active;

  always #5 clk = ~clk;

  uart_echo_ctrl #(.COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .echo_en      (echo_en),
    .rx_byte      (rx_byte),
    .rx_fifo_empty(rx_fifo_empty),
    .tx_fifo_full (tx_fifo_full),
    .rx_fifo_pop  (rx_fifo_pop),
    .tx_byte      (tx_byte),
    .transmit     (transmit),
    .echo_count   (echo_count),
    .active       (active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RX FIFO model: head byte appears the cycle after a pop.
  logic [7:0] rx_mem [64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_popped;
  assign rx_fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    fifo_popped = rx_fifo_pop;
    #1;
    if (fifo_popped && (rd_ptr != wr_ptr)) begin
      rx_byte = rx_mem[rd_ptr % 64];
      rd_ptr++;
    end
  end

  // Scoreboard monitor
  logic [7:0] exp_q [$];
  int         model_cnt = 0;
  int         pop_cnt = 0;
  logic       prev_pop = 1'b0;

  always @(negedge clk) begin
    if (rx_fifo_pop) begin
      pop_cnt++;
      check("pop_with_transmit", {31'b0, transmit}, 32'd0);
      check("pop_back_to_back", {31'b0, prev_pop}, 32'd0);
    end
    prev_pop = rx_fifo_pop;
    if (transmit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push: got 0x%0h, expected no push", tx_byte);
      end else begin
        check("tx_byte", {24'b0, tx_byte}, {24'b0, exp_q.pop_front()});
      end
      check("echo_count_at_push", {28'b0, echo_count}, model_cnt % 16);
      model_cnt++;
    end
    if (rst) model_cnt = 0;
  end

  int n_sent = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] stored);
    rx_mem[wr_ptr % 64] = b;
    wr_ptr++;
    exp_q.push_back(stored);
    n_sent++;
    if (stored == 8'h0D) begin
      exp_q.push_back(8'h0A);
      n_sent++;
    end
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || active || !rx_fifo_empty) && i < budget) begin
      tick();
      i++;
    end
    check("drain_in_budget", {31'b0, (i < budget)}, 32'd1);
  endtask

  task automatic wait_tx_byte(input logic [7:0] val, input int budget);
    int i = 0;
    while (tx_byte !== val && i < budget) begin
      tick();
      i++;
    end
    check("tx_byte_reached", {24'b0, tx_byte}, {24'b0, val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p;

    // Reset state
    tick(2);
    check("rst_pop", {31'b0, rx_fifo_pop}, 32'd0);
    check("rst_transmit", {31'b0, transmit}, 32'd0);
    check("rst_active", {31'b0, active}, 32'd0);
    check("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_echo_count", {28'b0, echo_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte and minimum latency
    echo_en = 1'b1;
    send(8'h41, 8'h41);
    lat = 0;
    while (!transmit && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 32'd3);
    drain(50);
    check("single_pops", pop_cnt, 32'd1);
    check("single_count", {28'b0, echo_count}, n_sent % 16);

    // CR expands into adjacent CR, LF pushes
    send(8'h0D, 8'h0D);
    lat = 0;
    while (!transmit && lat < 10) begin
      tick();
      lat++;
    end
    check("cr_first_byte", {24'b0, tx_byte}, 32'h0D);
    tick();
    check("lf_transmit", {31'b0, transmit}, 32'd1);
    check("lf_byte", {24'b0, tx_byte}, 32'h0A);
    drain(50);
    check("cr_count", {28'b0, echo_count}, n_sent % 16);

    // Backpressure holds the byte in PUSH
    tx_fifo_full = 1'b1;
    send(8'h42, 8'h42);
    wait_tx_byte(8'h42, 20);
    p = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      check("bp_no_transmit", {31'b0, transmit}, 32'd0);
      check("bp_hold_byte", {24'b0, tx_byte}, 32'h42);
      tick();
    end
    check("bp_no_extra_pop", pop_cnt, p);
    tx_fifo_full = 1'b0;
    #1;
    check("bp_release_transmit", {31'b0, transmit}, 32'd1);
    drain(50);
    check("bp_count", {28'b0, echo_count}, n_sent % 16);

    // Case conversion (build dependent)
    send(8'h61, EXP_LOWER_A);
    send(8'h7A, EXP_LOWER_Z);
    send(8'h5B, 8'h5B);
    drain(100);
    check("case_count", {28'b0, echo_count}, n_sent % 16);

    // echo_en gates new bytes only
    echo_en = 1'b0;
    p = pop_cnt;
    send(8'h55, 8'h55);
    tick(20);
    check("gate_no_pop", pop_cnt, p);
    check("gate_idle", {31'b0, active}, 32'd0);
    echo_en = 1'b1;
    drain(50);
    check("gate_count", {28'b0, echo_count}, n_sent % 16);

    // Reset while holding in PUSH_LF discards the LF
    tx_fifo_full = 1'b1;
    rx_mem[wr_ptr % 64] = 8'h0D;
    wr_ptr++;
    exp_q.push_back(8'h0D);
    wait_tx_byte(8'h0D, 20);
    tx_fifo_full = 1'b0;
    tick();
    tx_fifo_full = 1'b1;
    check("lf_pending_byte", {24'b0, tx_byte}, 32'h0A);
    check("lf_pending_active", {31'b0, active}, 32'd1);
    rst = 1'b1;
    tx_fifo_full = 1'b0;
    #1;
    check("rst_masks_transmit", {31'b0, transmit}, 32'd0);
    tick();
    rst = 1'b0;
    n_sent = 0;
    check("midrst_count", {28'b0, echo_count}, 32'd0);
    check("midrst_active", {31'b0, active}, 32'd0);
    check("midrst_tx_byte", {24'b0, tx_byte}, 32'd0);
    check("midrst_pop", {31'b0, rx_fifo_pop}, 32'd0);
    check("midrst_transmit", {31'b0, transmit}, 32'd0);
    tick(5);
    check("midrst_queue_empty", exp_q.size(), 32'd0);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) send(8'h30 + 8'(i), 8'h30 + 8'(i));
    drain(300);
    check("wrap_count", {28'b0, echo_count}, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
